tm1638_frame_sequencer: RTL

- Sequences one complete TM1638 display refresh frame as a stream of byte transactions to the serial byte shifter / strobe engine.
- Frame content: data-mode command, address command plus 16 display-RAM bytes, then display-control command.
- Accepts digit segments, LED bits and brightness from user logic. Triggers on a start pulse or an internal periodic refresh timer.
- Sits between the display-content registers and the low-level TM1638 serial interface (clk / strobe / dio generator).

---
 rtl/tm1638_frame_sequencer_if.sv | 11 +
 rtl/tm1638_frame_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_sequencer_if.sv
// Byte stream from the frame sequencer to the TM1638 serial shifter/strobe engine.
// tx_last marks the final byte of a transaction; the shifter raises strobe after it.
interface tm1638_frame_sequencer_if;
    logic [7:0] tx_byte;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_byte, output tx_last, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/tm1638_frame_sequencer.sv
// Emits one TM1638 refresh frame (data cmd, addr cmd + 16 RAM bytes, display ctrl)
// per start pulse or refresh tick, with a strobe gap after every transaction.
module tm1638_frame_sequencer #(
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int STB_GAP        = 50
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [63:0]                      disp_data,
    input  logic [7:0]                       led,
    input  logic [2:0]                       brightness,
    input  logic                             disp_on,
    tm1638_frame_sequencer_if.master         tx,
    output logic                             busy,
    output logic                             frame_done
);
    localparam int GW = (STB_GAP > 1) ? $clog2(STB_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DCMD, S_GAP1, S_ADDR, S_DATA, S_GAP2, S_DISP, S_GAP3
    } state_t;

    typedef struct packed {
        logic [63:0] digits;
        logic [7:0]  led;
        logic [2:0]  bright;
        logic        on;
    } snap_t;

    state_t        state, state_nxt;
    snap_t         snap;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    idx;
    logic          pending;
    logic          tick_refresh;
    logic          take;
    logic          fire_done;
    logic          gap_done;
    logic [7:0]    byte_c;
    logic          last_c;
    logic          valid_c;

    // Free-running refresh timer; runs regardless of FSM state.
    if (REFRESH_CYCLES > 0) begin : g_refresh
        localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
        logic [RW-1:0] rcnt;
        assign tick_refresh = (rcnt == RW'(REFRESH_CYCLES - 1));
        always_ff @(posedge clk) begin
            if (rst)               rcnt <= '0;
            else if (tick_refresh) rcnt <= '0;
            else                   rcnt <= rcnt + RW'(1);
        end
    end else begin : g_no_refresh
        assign tick_refresh = 1'b0;
    end

    assign gap_done = (gap_cnt == GW'(STB_GAP - 1));

    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        byte_c    = 8'h00;
        last_c    = 1'b0;
        take      = 1'b0;
        fire_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    take      = 1'b1;
                    state_nxt = S_DCMD;
                end
            end
            S_DCMD: begin
                valid_c = 1'b1;
                byte_c  = 8'h40;
                last_c  = 1'b1;
                if (tx.tx_ready) state_nxt = S_GAP1;
            end
            S_GAP1: if (gap_done) state_nxt = S_ADDR;
            S_ADDR: begin
                valid_c = 1'b1;
                byte_c  = 8'hC0;
                if (tx.tx_ready) state_nxt = S_DATA;
            end
            S_DATA: begin
                valid_c = 1'b1;
                // Even slots carry a digit, odd slots the matching LED in bit 0.
                byte_c  = idx[0] ? {7'b0, snap.led[idx[3:1]]}
                                 : snap.digits[{idx[3:1], 3'b000} +: 8];
                last_c  = (idx == 4'd15);
                if (tx.tx_ready && idx == 4'd15) state_nxt = S_GAP2;
            end
            S_GAP2: if (gap_done) state_nxt = S_DISP;
            S_DISP: begin
                valid_c = 1'b1;
                byte_c  = snap.on ? {5'b10001, snap.bright} : 8'h80;
                last_c  = 1'b1;
                if (tx.tx_ready) state_nxt = S_GAP3;
            end
            S_GAP3: begin
                if (gap_done) begin
                    fire_done = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            snap       <= '0;
            gap_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= fire_done;
            // A request landing in the same cycle the frame is taken stays queued.
            pending    <= (pending & ~take) | start | tick_refresh;
            if (take)
                snap <= '{digits: disp_data, led: led, bright: brightness, on: disp_on};
            if (state_nxt != state)
                gap_cnt <= '0;
            else if (state == S_GAP1 || state == S_GAP2 || state == S_GAP3)
                gap_cnt <= gap_cnt + GW'(1);
            if (state == S_ADDR)
                idx <= '0;
            else if (state == S_DATA && tx.tx_ready)
                idx <= idx + 4'd1;
        end
    end

    assign tx.tx_valid = valid_c;
    assign tx.tx_byte  = byte_c;
    assign tx.tx_last  = last_c;
    assign busy        = (state != S_IDLE);
endmodule
